// File: rtl/host_load_ctrl_if.sv
// Host command bus between the decoder and host_load_ctrl.
// Carries the level-held command flags, target address and data byte.
interface host_load_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              fetch_w;
  logic              fetch_inp;
  logic              fetch_ins;
  logic              start;
  logic [ADDR_W-1:0] dma_address;
  logic [DATA_W-1:0] data_in;

  modport master (
    output fetch_w,
    output fetch_inp,
    output fetch_ins,
    output start,
    output dma_address,
    output data_in
  );

  modport slave (
    input fetch_w,
    input fetch_inp,
    input fetch_ins,
    input start,
    input dma_address,
    input data_in
  );
endinterface

// File: rtl/host_load_ctrl.sv
// Turns held decoder flags into one-shot memory write strobes and a
// control-unit start pulse; blocks new loads until the program is done.
module host_load_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  host_load_ctrl_if.slave   cmd,
  input  logic              done,
  output logic              w_we,
  output logic              inp_we,
  output logic              ins_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cu_start,
  output logic              busy,
  output logic [ADDR_W:0]   ins_count,
  output logic              cmd_err
);

  typedef enum logic [2:0] {
    C_NONE,
    C_W,
    C_INP,
    C_INS,
    C_STRT,
    C_MULTI
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN
  } state_t;

  localparam logic [ADDR_W:0] CNT_MAX = '1;

  state_t            state_q;
  state_t            state_d;
  cmd_t              cur_type;
  cmd_t              prev_type;
  logic [ADDR_W-1:0] prev_addr;
  logic [2:0]        n_flags;
  logic              is_new;
  logic              w_we_d;
  logic              inp_we_d;
  logic              ins_we_d;
  logic              ins_inc;
  logic              err_set;

  // Classify this cycle's flags and detect a fresh command.
  always_comb begin
    n_flags  = {2'b00, cmd.fetch_w}
             + {2'b00, cmd.fetch_inp}
             + {2'b00, cmd.fetch_ins}
             + {2'b00, cmd.start};
    cur_type = C_NONE;
    if (n_flags > 3'd1) begin
      cur_type = C_MULTI;
    end else begin
      unique case (1'b1)
        cmd.fetch_w:   cur_type = C_W;
        cmd.fetch_inp: cur_type = C_INP;
        cmd.fetch_ins: cur_type = C_INS;
        cmd.start:     cur_type = C_STRT;
        default:       cur_type = C_NONE;
      endcase
    end
    is_new = (cur_type != C_NONE) &&
             ((cur_type != prev_type) ||
              (cmd.dma_address != prev_addr));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle actions.
  always_comb begin
    state_d  = state_q;
    w_we_d   = 1'b0;
    inp_we_d = 1'b0;
    ins_we_d = 1'b0;
    ins_inc  = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_new) begin
          case (cur_type)
            C_W:   w_we_d = 1'b1;
            C_INP: inp_we_d = 1'b1;
            C_INS: begin
              ins_we_d = 1'b1;
              ins_inc  = 1'b1;
            end
            C_STRT: begin
              if (ins_count != '0) begin
                state_d = S_START;
              end else begin
                err_set = 1'b1;
              end
            end
            C_MULTI: err_set = 1'b1;
            default: ;
          endcase
        end
      end
      S_START: begin
        err_set = is_new;
        state_d = S_RUN;
      end
      S_RUN: begin
        err_set = is_new;
        if (done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs and edge-tracking history.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_type <= C_NONE;
      prev_addr <= '0;
      w_we      <= 1'b0;
      inp_we    <= 1'b0;
      ins_we    <= 1'b0;
      cu_start  <= 1'b0;
      busy      <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      ins_count <= '0;
      cmd_err   <= 1'b0;
    end else begin
      prev_type <= cur_type;
      prev_addr <= cmd.dma_address;
      w_we      <= w_we_d;
      inp_we    <= inp_we_d;
      ins_we    <= ins_we_d;
      cu_start  <= (state_d == S_START);
      busy      <= (state_d != S_IDLE);
      if (w_we_d || inp_we_d || ins_we_d) begin
        wr_addr <= cmd.dma_address;
        wr_data <= cmd.data_in;
      end
      if (ins_inc && (ins_count != CNT_MAX)) begin
        ins_count <= ins_count + 1'b1;
      end
      if (err_set) begin
        cmd_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/host_load_ctrl.md
# host_load_ctrl

Command consumer that sits directly downstream of the host command decoder. It turns level-held decoder flags (fetch_w, fetch_inp, fetch_ins, start) plus the host data byte into single-cycle write strobes for the weight, input and instruction memories. It then hands off to the control unit with a one-cycle start pulse and blocks further loads until the control unit reports done.

## Interface
Parameters:
- DATA_W, 8, width of host data byte and memory write data
- ADDR_W, 4, width of dma_address and memory write address

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- fetch_w  in  1  decoder: load weight byte
- fetch_inp  in  1  decoder: load input byte
- fetch_ins  in  1  decoder: load instruction byte
- start  in  1  decoder: start request
- dma_address  in  ADDR_W  decoder: target address
- data_in  in  DATA_W  host data byte, valid with the fetch flag
- done  in  1  control unit: program finished (pulse or level)
- w_we  out  1  weight memory write strobe
- inp_we  out  1  input memory write strobe
- ins_we  out  1  instruction memory write strobe
- wr_addr  out  ADDR_W  shared write address
- wr_data  out  DATA_W  shared write data
- cu_start  out  1  one-cycle start pulse to control unit
- busy  out  1  high while in START or RUN
- ins_count  out  ADDR_W+1  instruction writes since reset, saturating at 2^(ADDR_W+1)-1
- cmd_err  out  1  sticky protocol-error flag

## Operation
- Command type each cycle:
  - NONE if no flag is set.
  - W, INP, INS or STRT if exactly one flag is set.
  - MULTI if more than one flag is set.
- Edge detection:
  - prev_type and prev_addr are registered every cycle.
  - A command is new when its type is not NONE and either type ≠ prev_type or dma_address ≠ prev_addr.
  - A held command therefore acts exactly once.
  - Changing the address while holding the same flag is a new command.
- States: IDLE, START, RUN.
- IDLE:
  - New W, INP or INS: one cycle later, pulse the matching *_we for 1 cycle, with wr_addr and wr_data captured from that cycle's dma_address and data_in.
  - New INS also increments ins_count, saturating at max.
  - New STRT with ins_count ≠ 0: go to START.
  - New STRT with ins_count = 0: set cmd_err, stay in IDLE.
  - MULTI: set cmd_err, no write, no transition.
  - done: ignored.
- START:
  - cu_start = 1 for exactly this one cycle; go to RUN unconditionally.
  - Any new command in this cycle sets cmd_err and is dropped.
- RUN:
  - Wait for done = 1, then go to IDLE the next cycle.
  - Any new command, including STRT, sets cmd_err and is dropped; no *_we is issued.
  - If done and a new command occur in the same cycle, the command is dropped, cmd_err is set, and the state goes to IDLE.
- Edge tracking (prev_type/prev_addr) updates in every state. A command held across the RUN→IDLE return is not re-executed.
- cmd_err clears only on reset. ins_count clears only on reset.

## Timing
- Reset values:
  - w_we, inp_we, ins_we, cu_start, busy, cmd_err = 0.
  - wr_addr, wr_data, ins_count = 0.
  - State = IDLE.
  - prev_type = NONE, prev_addr = 0.
- Reset asserted mid-RUN or mid-START returns to IDLE on the next edge. No cu_start is issued, and no stale *_we fires after reset.
- All outputs are registered; the logic has no combinational input-to-output paths.
- Write latency: command seen at edge n gives *_we high during cycle n+1 only. wr_addr and wr_data hold their values until the next write.
- Start latency: STRT seen at edge n puts the block in START during cycle n+1 (cu_start = 1, busy = 1), then RUN from cycle n+2.
- busy is 1 in START and RUN, 0 in IDLE. It falls in the cycle after done is sampled.
- Back-to-back distinct commands on consecutive cycles (e.g. W@3 then W@4) yield consecutive *_we pulses with no bubble.
- At most one *_we is high in any cycle. *_we and cu_start are never high together.

## Test plan
- Reset, hold fetch_w with address 5 and data 0xA7 for 4 cycles → exactly one w_we pulse with wr_addr = 5 and wr_data = 0xA7; cmd_err = 0.
- fetch_ins held while the address steps 0,1,2 each cycle, with data 0x10,0x11,0x12 → three consecutive ins_we pulses with matching address and data; ins_count = 3.
- start with ins_count = 0 → no cu_start, cmd_err = 1, busy = 0. After reset, load 1 instruction then start held 3 cycles → single cu_start pulse and busy = 1.
- In RUN, issue fetch_inp at address 2 → no inp_we, cmd_err = 1. Pulse done → busy = 0 one cycle later. A fresh fetch_inp at address 2 then writes once.
- Assert fetch_w and fetch_inp together in IDLE → no strobes, cmd_err = 1, state stays IDLE.
- Assert reset during RUN with start still held → outputs go to reset values. After reset release, the held start is seen as new but ins_count = 0, so cmd_err = 1 and there is no cu_start.
